// File: rtl/pin_stream_deserializer_if.sv
// Byte-in / word-out stream bundle for pin_stream_deserializer.
// The slave modport is the deserializer's view; the master modport is the host/core side.
interface pin_stream_deserializer_if #(
   parameter int WORD_BYTES = 4
);
   logic                      pin_in_ready;
   logic                      pin_in_valid;
   logic [7:0]                pin_in_data;
   logic                      pin_in_last;
   logic                      out_valid;
   logic                      out_ready;
   logic [8*WORD_BYTES-1:0]   out_data;
   logic [WORD_BYTES-1:0]     out_keep;
   logic                      out_last;

   modport slave (
      output pin_in_ready,
      input  pin_in_valid, pin_in_data, pin_in_last,
      output out_valid, out_data, out_keep, out_last,
      input  out_ready
   );

   modport master (
      input  pin_in_ready,
      output pin_in_valid, pin_in_data, pin_in_last,
      input  out_valid, out_data, out_keep, out_last,
      output out_ready
   );
endinterface

// File: rtl/pin_stream_deserializer.sv
// Packs pad-level bytes little-endian into words and queues them in a small FIFO.
// Optional: define PIN_STREAM_DESERIALIZER_BYTE_COUNT_EN to add the rx_byte_count port.
module pin_stream_deserializer #(
   parameter int WORD_BYTES = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     resetb,
`ifdef PIN_STREAM_DESERIALIZER_BYTE_COUNT_EN
   output logic [15:0]              rx_byte_count,
`endif
   pin_stream_deserializer_if.slave bus
);
   localparam int DW = 8 * WORD_BYTES;
   localparam int LW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;

   logic [LW-1:0]         lane_idx_r;
   logic [DW-1:0]         asm_data_r;
   logic [DW-1:0]         mem_data_r [FIFO_DEPTH];
   logic [WORD_BYTES-1:0] mem_keep_r [FIFO_DEPTH];
   logic                  mem_last_r [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr_r;
   logic [PW-1:0]         rd_ptr_r;
   logic [CW-1:0]         count_r;
   logic                  ready_r;
   logic                  out_valid_r;
   logic [DW-1:0]         out_data_r;
   logic [WORD_BYTES-1:0] out_keep_r;
   logic                  out_last_r;

   logic                  accept_s;
   logic                  done_s;
   logic                  pop_s;
   logic [DW-1:0]         word_s;
   logic [WORD_BYTES-1:0] keep_s;
   logic [CW-1:0]         count_next_s;
   logic [CW-1:0]         count_after_pop_s;
   logic [PW-1:0]         rd_ptr_next_s;
   logic [DW-1:0]         head_data_s;
   logic [WORD_BYTES-1:0] head_keep_s;
   logic                  head_last_s;

   assign bus.pin_in_ready = ready_r;
   assign bus.out_valid    = out_valid_r;
   assign bus.out_data     = out_data_r;
   assign bus.out_keep     = out_keep_r;
   assign bus.out_last     = out_last_r;

   // Handshakes, word merge, next FIFO occupancy and the head entry to present next.
   always_comb begin
      accept_s = bus.pin_in_valid & ready_r;
      pop_s    = out_valid_r & bus.out_ready;
      word_s   = asm_data_r;
      keep_s   = '0;
      for (int i = 0; i < WORD_BYTES; i++) begin
         if (lane_idx_r == LW'(i)) begin
            word_s[8*i +: 8] = bus.pin_in_data;
         end else begin
            word_s[8*i +: 8] = asm_data_r[8*i +: 8];
         end
         if (LW'(i) <= lane_idx_r) begin
            keep_s[i] = 1'b1;
         end else begin
            keep_s[i] = 1'b0;
         end
      end
      done_s            = accept_s & ((lane_idx_r == LW'(WORD_BYTES - 1)) | bus.pin_in_last);
      count_after_pop_s = count_r - CW'(pop_s);
      count_next_s      = count_after_pop_s + CW'(done_s);
      if (pop_s) begin
         rd_ptr_next_s = rd_ptr_r + PW'(1'b1);
      end else begin
         rd_ptr_next_s = rd_ptr_r;
      end
      // When the FIFO drains to empty the outputs keep the last head value.
      if (count_next_s == '0) begin
         head_data_s = out_data_r;
         head_keep_s = out_keep_r;
         head_last_s = out_last_r;
      end else if (count_after_pop_s == '0) begin
         head_data_s = word_s;
         head_keep_s = keep_s;
         head_last_s = bus.pin_in_last;
      end else begin
         head_data_s = mem_data_r[rd_ptr_next_s];
         head_keep_s = mem_keep_r[rd_ptr_next_s];
         head_last_s = mem_last_r[rd_ptr_next_s];
      end
   end

   // Word assembly, FIFO storage/pointers and registered outputs.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         lane_idx_r  <= '0;
         asm_data_r  <= '0;
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         count_r     <= '0;
         ready_r     <= 1'b0;
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_keep_r  <= '0;
         out_last_r  <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_data_r[i] <= '0;
            mem_keep_r[i] <= '0;
            mem_last_r[i] <= 1'b0;
         end
      end else begin
         if (done_s) begin
            lane_idx_r           <= '0;
            asm_data_r           <= '0;
            mem_data_r[wr_ptr_r] <= word_s;
            mem_keep_r[wr_ptr_r] <= keep_s;
            mem_last_r[wr_ptr_r] <= bus.pin_in_last;
            wr_ptr_r             <= wr_ptr_r + PW'(1'b1);
         end else if (accept_s) begin
            lane_idx_r <= lane_idx_r + LW'(1'b1);
            asm_data_r <= word_s;
         end
         rd_ptr_r    <= rd_ptr_next_s;
         count_r     <= count_next_s;
         // Any accepted byte may complete a word, so ready requires a free entry up front.
         ready_r     <= (count_next_s < CW'(FIFO_DEPTH));
         out_valid_r <= (count_next_s != '0);
         out_data_r  <= head_data_s;
         out_keep_r  <= head_keep_s;
         out_last_r  <= head_last_s;
      end
   end

`ifdef PIN_STREAM_DESERIALIZER_BYTE_COUNT_EN
   // Free-running count of accepted bytes, wrapping at 16 bits.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         rx_byte_count <= 16'h0000;
      end else if (accept_s) begin
         rx_byte_count <= rx_byte_count + 16'h0001;
      end
   end
`endif
endmodule

// File: tb/tb_pin_stream_deserializer.sv
// Scoreboard bench for pin_stream_deserializer: a byte-level model pushes expected words,
// a negedge monitor compares the presented head word against the queue front.
module tb_pin_stream_deserializer;
   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } exp_t;

   logic clock  = 1'b0;
   logic resetb = 1'b0;
   always #5 clock = ~clock;

   pin_stream_deserializer_if #(.WORD_BYTES(4)) bus ();
`ifdef PIN_STREAM_DESERIALIZER_BYTE_COUNT_EN
   logic [15:0] rx_byte_count;
`endif

   pin_stream_deserializer #(.WORD_BYTES(4), .FIFO_DEPTH(4)) dut (
      .clock         (clock),
      .resetb        (resetb),
`ifdef PIN_STREAM_DESERIALIZER_BYTE_COUNT_EN
      .rx_byte_count (rx_byte_count),
`endif
      .bus           (bus)
   );

   int          total = 0;
   int          bad   = 0;
   exp_t        exp_q [$];
   exp_t        mon_e;
   logic [31:0] m_word = 32'h0;
   logic [3:0]  m_keep = 4'h0;
   int          m_lane = 0;

   // Head word must always match the oldest expected word; pop it on a handshake.
   always @(negedge clock) begin
      if (resetb && bus.out_valid) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL monitor_unexpected_word: got data=%h keep=%h last=%b want no word",
                     bus.out_data, bus.out_keep, bus.out_last);
         end else begin
            mon_e = exp_q[0];
            if (bus.out_data !== mon_e.data || bus.out_keep !== mon_e.keep || bus.out_last !== mon_e.last) begin
               bad++;
               $display("FAIL monitor_word: got data=%h keep=%h last=%b want data=%h keep=%h last=%b",
                        bus.out_data, bus.out_keep, bus.out_last, mon_e.data, mon_e.keep, mon_e.last);
            end
            if (bus.out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic model_accept(input logic [7:0] b, input logic l);
      m_word[8*m_lane +: 8] = b;
      m_keep[m_lane]        = 1'b1;
      if (m_lane == 3 || l) begin
         exp_q.push_back('{data: m_word, keep: m_keep, last: l});
         m_word = 32'h0;
         m_keep = 4'h0;
         m_lane = 0;
      end else begin
         m_lane++;
      end
   endtask

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic send_byte(input logic [7:0] b, input logic l);
      int waited = 0;
      bus.pin_in_valid = 1'b1;
      bus.pin_in_data  = b;
      bus.pin_in_last  = l;
      forever begin
         @(negedge clock);
         if (bus.pin_in_ready === 1'b1) break;
         waited++;
         if (waited > 200) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got ready=%b for 200 cycles want 1 (byte %h)", bus.pin_in_ready, b);
            break;
         end
      end
      if (waited <= 200) model_accept(b, l);
      @(posedge clock);
      #1;
      bus.pin_in_valid = 1'b0;
      bus.pin_in_last  = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clock);
         n++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s_drain: got %0d words pending want 0", name, exp_q.size());
      end
      @(negedge clock);
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL %s_empty: got out_valid=%b want 0", name, bus.out_valid);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      resetb = 1'b0;
      repeat (2) @(negedge clock);
      total++;
      if ({bus.pin_in_ready, bus.out_valid, bus.out_last, bus.out_keep, bus.out_data} !== 39'h0) begin
         bad++;
         $display("FAIL reset_outputs: got ready=%b valid=%b last=%b keep=%h data=%h want all 0",
                  bus.pin_in_ready, bus.out_valid, bus.out_last, bus.out_keep, bus.out_data);
      end
      #1 resetb = 1'b1;
      @(posedge clock);
      #1;
      total++;
      if (bus.pin_in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready_first_edge: got %b want 1", bus.pin_in_ready);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         total++;
         if (bus.out_valid !== 1'b0 || bus.out_keep !== 4'h0 || bus.out_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_idle: got valid=%b keep=%h data=%h want 0/0/0",
                     bus.out_valid, bus.out_keep, bus.out_data);
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_full_word();
      bus.out_ready = 1'b1;
      send_byte(8'h04, 1'b0);
      send_byte(8'h03, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h01, 1'b1);
      @(negedge clock);
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h01020304 || bus.out_keep !== 4'hF || bus.out_last !== 1'b1) begin
         bad++;
         $display("FAIL full_word_latency: got valid=%b data=%h keep=%h last=%b want 1/01020304/f/1",
                  bus.out_valid, bus.out_data, bus.out_keep, bus.out_last);
      end
      @(posedge clock);
      #1;
      wait_drain("full_word");
   endtask

   task automatic test_short_frame();
      bus.out_ready = 1'b1;
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b1);
      @(negedge clock);
      total++;
      if (bus.out_data !== 32'h0000BBAA || bus.out_keep !== 4'h3 || bus.out_last !== 1'b1) begin
         bad++;
         $display("FAIL short_frame_word: got data=%h keep=%h last=%b want 0000bbaa/3/1",
                  bus.out_data, bus.out_keep, bus.out_last);
      end
      @(posedge clock);
      #1;
      send_byte(8'hCC, 1'b1);
      @(negedge clock);
      total++;
      if (bus.out_data !== 32'h000000CC || bus.out_keep !== 4'h1) begin
         bad++;
         $display("FAIL short_frame_lane0: got data=%h keep=%h want 000000cc/1", bus.out_data, bus.out_keep);
      end
      @(posedge clock);
      #1;
      wait_drain("short_frame");
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i), 1'b0);
      @(negedge clock);
      total++;
      if (bus.pin_in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
         bad++;
         $display("FAIL backpressure_full: got ready=%b valid=%b want 0/1", bus.pin_in_ready, bus.out_valid);
      end
      fork
         send_byte(8'h20, 1'b0);
         begin
            for (int k = 0; k < 4; k++) begin
               @(negedge clock);
               total++;
               if (bus.pin_in_ready !== 1'b0) begin
                  bad++;
                  $display("FAIL backpressure_hold: got ready=%b want 0", bus.pin_in_ready);
               end
            end
            @(posedge clock);
            #1 bus.out_ready = 1'b1;
         end
      join
      send_byte(8'h21, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h23, 1'b1);
      wait_drain("backpressure");
   endtask

   task automatic test_push_pop_full();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 15; i++) send_byte(8'h40 + 8'(i), 1'b0);
      fork
         begin
            bus.out_ready = 1'b1;
            for (int i = 15; i < 23; i++) send_byte(8'h40 + 8'(i), (i == 22) ? 1'b1 : 1'b0);
         end
         begin
            for (int k = 0; k < 8; k++) begin
               @(negedge clock);
               total++;
               if (bus.pin_in_ready !== 1'b1) begin
                  bad++;
                  $display("FAIL push_pop_ready: got ready=%b want 1 (cycle %0d)", bus.pin_in_ready, k);
               end
            end
         end
      join
      wait_drain("push_pop");
   endtask

   task automatic test_mid_reset();
      bus.out_ready = 1'b1;
      send_byte(8'h11, 1'b0);
      send_byte(8'h12, 1'b0);
      resetb = 1'b0;
      #1;
      total++;
      if ({bus.pin_in_ready, bus.out_valid, bus.out_last, bus.out_keep, bus.out_data} !== 39'h0) begin
         bad++;
         $display("FAIL mid_reset_outputs: got ready=%b valid=%b keep=%h data=%h want all 0",
                  bus.pin_in_ready, bus.out_valid, bus.out_keep, bus.out_data);
      end
      m_word = 32'h0;
      m_keep = 4'h0;
      m_lane = 0;
      exp_q.delete();
      @(negedge clock);
      #1 resetb = 1'b1;
      @(posedge clock);
      #1;
      send_byte(8'h21, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h23, 1'b0);
      send_byte(8'h24, 1'b1);
      @(negedge clock);
      total++;
      if (bus.out_data !== 32'h24232221 || bus.out_keep !== 4'hF || bus.out_last !== 1'b1) begin
         bad++;
         $display("FAIL mid_reset_clean_word: got data=%h keep=%h last=%b want 24232221/f/1",
                  bus.out_data, bus.out_keep, bus.out_last);
      end
`ifdef PIN_STREAM_DESERIALIZER_BYTE_COUNT_EN
      total++;
      if (rx_byte_count !== 16'd4) begin
         bad++;
         $display("FAIL mid_reset_byte_count: got %0d want 4", rx_byte_count);
      end
`endif
      @(posedge clock);
      #1;
      wait_drain("mid_reset");
   endtask

   initial begin
      bus.pin_in_valid = 1'b0;
      bus.pin_in_data  = 8'h00;
      bus.pin_in_last  = 1'b0;
      bus.out_ready    = 1'b0;
      test_reset();
      test_full_word();
      test_short_frame();
      test_backpressure();
      test_push_pop_full();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion want finish before 200000");
      $fatal(1, "watchdog expired");
   end
endmodule
